// File: rtl/dac_sample_player.sv
// dac_sample_player: FIFO-buffered sample player feeding an 8-bit DAC.
// Samples are queued through a valid/ready port and played out at a
// programmable rate (one sample every div+1 clocks while en is high).
// An empty FIFO at a sample tick raises a sticky underrun flag.
// Optional feature: define DAC_PLAYER_IRQ_EN to add the registered irq output.
module dac_sample_player #(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DIV_W-1:0]           div,
    input  logic                       flush,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       clr_underrun,
    output logic                       dac_ena,
    output logic [7:0]                 dac_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun
`ifdef DAC_PLAYER_IRQ_EN
   ,output logic                       irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0]    ZERO_LVL = LW'(0);
    localparam logic [LW-1:0]    ONE_LVL  = LW'(1);
    localparam logic [AW-1:0]    PTR_ZERO = AW'(0);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    // Sample storage; contents are only meaningful between the pointers,
    // so the array carries no reset.
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_dac_data;
    logic             r_dac_ena;
    logic             r_underrun;

    logic w_tick;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_starve;

    // Tick and FIFO handshake decode. s_ready depends only on the registered
    // level (plus flush), never on this cycle's pop.
    always_comb begin
        w_tick   = en && (r_cnt >= div);
        w_full   = (r_level == FULL_LVL);
        s_ready  = (!w_full) || flush;
        w_push   = s_valid && s_ready && !flush;
        w_pop    = w_tick && (r_level != ZERO_LVL) && !flush;
        w_starve = w_tick && (r_level == ZERO_LVL);
    end

    // Prescaler: held at zero while disabled, wraps on every tick. The >=
    // compare makes a lowered div take effect on the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
        end else if (!en) begin
            r_cnt <= CNT_ZERO;
        end else if (w_tick) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= ZERO_LVL;
        end else if (flush) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= ZERO_LVL;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + ONE_LVL;
                2'b01:   r_level <= r_level - ONE_LVL;
                default: r_level <= r_level;
            endcase
        end
    end

    // DAC data register: loads the popped head entry, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dac_data <= 8'h00;
        end else if (w_pop) begin
            r_dac_data <= r_mem[r_rd_ptr];
        end else begin
            r_dac_data <= r_dac_data;
        end
    end

    // DAC enable follows en with one cycle of delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dac_ena <= 1'b0;
        end else begin
            r_dac_ena <= en;
        end
    end

    // Sticky underrun: a starved tick sets it and beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_starve) begin
            r_underrun <= 1'b1;
        end else if (clr_underrun) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= r_underrun;
        end
    end

`ifdef DAC_PLAYER_IRQ_EN
    localparam logic [LW-1:0] HALF_LVL = LW'(DEPTH / 2);
    logic r_irq;

    // Interrupt request: FIFO at or below half while playing, or underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (en && (r_level <= HALF_LVL)) || r_underrun;
        end
    end

    assign irq = r_irq;
`endif

    assign dac_ena  = r_dac_ena;
    assign dac_data = r_dac_data;
    assign level    = r_level;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_dac_sample_player.sv
// Directed testbench for dac_sample_player (DEPTH=16, DIV_W=16).
module tb_dac_sample_player;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic        flush;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        clr_underrun;
    logic        dac_ena;
    logic [7:0]  dac_data;
    logic [4:0]  level;
    logic        underrun;
`ifdef DAC_PLAYER_IRQ_EN
    logic        irq;
`endif

    int n_total;
    int n_bad;

    dac_sample_player #(.DEPTH(16), .DIV_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div          (div),
        .flush        (flush),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .clr_underrun (clr_underrun),
        .dac_ena      (dac_ena),
        .dac_data     (dac_data),
        .level        (level),
        .underrun     (underrun)
`ifdef DAC_PLAYER_IRQ_EN
       ,.irq          (irq)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        cyc(1);
        s_valid = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b1;
        en           = 1'b0;
        div          = 16'd3;
        flush        = 1'b0;
        s_data       = 8'h00;
        s_valid      = 1'b0;
        clr_underrun = 1'b0;

        // Reset values
        #12;
        check("rst_ena",      {31'd0, dac_ena},  32'd0);
        check("rst_data",     {24'd0, dac_data}, 32'h00);
        check("rst_level",    {27'd0, level},    32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_ready",    {31'd0, s_ready},  32'd1);
`ifdef DAC_PLAYER_IRQ_EN
        check("rst_irq",      {31'd0, irq},      32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic playback, div=3: tick every 4 cycles, data one cycle after tick
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("a_level3", {27'd0, level}, 32'd3);
        en = 1'b1;
        cyc(1);
        check("a_ena", {31'd0, dac_ena}, 32'd1);
        cyc(2);
        check("a_pre", {24'd0, dac_data}, 32'h00);
        cyc(1);
        check("a_s1", {24'd0, dac_data}, 32'h11);
        cyc(3);
        check("a_s1_hold", {24'd0, dac_data}, 32'h11);
        cyc(1);
        check("a_s2", {24'd0, dac_data}, 32'h22);
        cyc(4);
        check("a_s3", {24'd0, dac_data}, 32'h33);
        check("a_lvl0", {27'd0, level}, 32'd0);
        cyc(3);
        check("a_no_urun", {31'd0, underrun}, 32'd0);
        cyc(1);
        check("a_urun", {31'd0, underrun}, 32'd1);
        en           = 1'b0;
        clr_underrun = 1'b1;
        cyc(1);
        clr_underrun = 1'b0;
        check("a_clr", {31'd0, underrun}, 32'd0);
        check("a_ena_off", {31'd0, dac_ena}, 32'd0);
        check("a_hold", {24'd0, dac_data}, 32'h33);

        // Fill to DEPTH with en=0, overflow attempt, then drain at div=0
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        check("b_full_lvl", {27'd0, level}, 32'd16);
        check("b_full_rdy", {31'd0, s_ready}, 32'd0);
        push(8'hEE);
        check("b_ovf_lvl", {27'd0, level}, 32'd16);
        div = 16'd0;
        en  = 1'b1;
        cyc(1);
        check("b_d0", {24'd0, dac_data}, 32'h40);
        check("b_lvl15", {27'd0, level}, 32'd15);
        cyc(1);
        check("b_d1", {24'd0, dac_data}, 32'h41);
        cyc(14);
        check("b_d15", {24'd0, dac_data}, 32'h4F);
        check("b_lvl0", {27'd0, level}, 32'd0);
        check("b_no_urun", {31'd0, underrun}, 32'd0);
        cyc(1);
        check("b_urun", {31'd0, underrun}, 32'd1);
        check("b_hold", {24'd0, dac_data}, 32'h4F);
        clr_underrun = 1'b1;
        cyc(1);
        check("b_set_wins", {31'd0, underrun}, 32'd1);
        en = 1'b0;
        cyc(1);
        clr_underrun = 1'b0;
        check("b_clr", {31'd0, underrun}, 32'd0);

        // Push coinciding with a starved tick is stored, underrun still sets
        en      = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        cyc(1);
        s_valid = 1'b0;
        check("c_lvl1", {27'd0, level}, 32'd1);
        check("c_urun", {31'd0, underrun}, 32'd1);
        check("c_hold", {24'd0, dac_data}, 32'h4F);
        clr_underrun = 1'b1;
        cyc(1);
        clr_underrun = 1'b0;
        check("c_out", {24'd0, dac_data}, 32'hA5);
        check("c_clr", {31'd0, underrun}, 32'd0);
        cyc(1);
        check("c_urun2", {31'd0, underrun}, 32'd1);
        check("c_hold2", {24'd0, dac_data}, 32'hA5);
        en           = 1'b0;
        clr_underrun = 1'b1;
        cyc(1);
        clr_underrun = 1'b0;
        check("c_clr2", {31'd0, underrun}, 32'd0);

        // Flush with a full FIFO and a simultaneous push
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h77;
        #1;
        check("f_ready", {31'd0, s_ready}, 32'd1);
        cyc(1);
        flush   = 1'b0;
        s_valid = 1'b0;
        check("f_lvl", {27'd0, level}, 32'd0);
        check("f_data", {24'd0, dac_data}, 32'hA5);
        check("f_urun", {31'd0, underrun}, 32'd0);
        push(8'h5A);
        check("f_lvl1", {27'd0, level}, 32'd1);
        en = 1'b1;
        cyc(1);
        en = 1'b0;
        check("f_after", {24'd0, dac_data}, 32'h5A);

        // Asynchronous reset mid-playback with level=7
        en = 1'b1;
        cyc(1);
        en = 1'b0;
        check("r_urun_pre", {31'd0, underrun}, 32'd1);
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
        check("r_lvl7", {27'd0, level}, 32'd7);
        div = 16'd15;
        en  = 1'b1;
        cyc(3);
        check("r_ena_pre", {31'd0, dac_ena}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("r_ena", {31'd0, dac_ena}, 32'd0);
        check("r_data", {24'd0, dac_data}, 32'h00);
        check("r_lvl", {27'd0, level}, 32'd0);
        check("r_urun", {31'd0, underrun}, 32'd0);
        check("r_ready", {31'd0, s_ready}, 32'd1);
        en  = 1'b0;
        rst = 1'b0;
        push(8'hC3);
        check("r_first_push", {27'd0, level}, 32'd1);

        // Lowering div mid-count ticks on the next cycle
        en = 1'b1;
        cyc(5);
        check("d_no_tick", {24'd0, dac_data}, 32'h00);
        div = 16'd2;
        cyc(1);
        check("d_tick", {24'd0, dac_data}, 32'hC3);
        check("d_lvl0", {27'd0, level}, 32'd0);
        en = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
